psum_scatter_acc: RTL

- Consumes the 26-bit coordinate-tagged products of the sparse multiplier stage and scatter-accumulates them into a register-file partial-sum tile indexed by output (x,y).
- On the tile's last product it drains the tile in raster order to the writeback stage, zeroing each entry as it is sent.
- Sits directly downstream of the multiplier array and upstream of output writeback.

---
 rtl/psum_scatter_acc.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/psum_scatter_acc.sv
// psum_scatter_acc: scatter-accumulates coordinate-tagged products into a
// partial-sum tile, then drains the tile in raster order, zeroing entries.
// Ports: clk, reset (async, high), clear (sync tile abort)
//   in_valid/in_ready/in_data{x,y,value}/in_last : product stream
//   out_valid/out_ready/out_data/out_x/out_y/out_last : drained entries
//   drop_cnt : out-of-range products this tile, busy : draining
// Macro PSUM_SAT_EN: saturating accumulate plus sticky sat_flag output.
module psum_scatter_acc #(
   parameter int OUT_W = 8,
   parameter int OUT_H = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [25:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [3:0]       out_x,
   output logic [3:0]       out_y,
   output logic             out_last,
   output logic [7:0]       drop_cnt,
   output logic             busy
`ifdef PSUM_SAT_EN
   ,
   output logic             sat_flag
`endif
);

   localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [XW-1:0] XMAX = XW'(OUT_W - 1);
   localparam logic [YW-1:0] YMAX = YW'(OUT_H - 1);

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t state;

   logic [ACC_W-1:0] acc [OUT_H][OUT_W];

   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;

   logic [4:0]  in_x;
   logic [4:0]  in_y;
   logic [15:0] in_v;
   logic        in_range;
   logic [XW-1:0] ax;
   logic [YW-1:0] ay;
   logic        hs;
   logic        out_hs;

   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] sum_res;

   assign in_x = in_data[25:21];
   assign in_y = in_data[20:16];
   assign in_v = in_data[15:0];

   // Negative coordinates have the sign bit set and are never in range.
   assign in_range = !in_x[4] && !in_y[4]
                   && (int'(in_x[3:0]) < OUT_W)
                   && (int'(in_y[3:0]) < OUT_H);

   assign ax = in_x[XW-1:0];
   assign ay = in_y[YW-1:0];

   assign in_ready = (state == ACCUM);
   assign hs       = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   // A same-cycle clear means the product lands on a zeroed entry.
   assign base = clear ? '0 : acc[ay][ax];

`ifdef PSUM_SAT_EN
   logic [ACC_W:0] sum_ext;
   logic           ovf;
   logic           sat_hit;

   assign sum_ext = {base[ACC_W-1], base}
                  + {{(ACC_W + 1 - 16){in_v[15]}}, in_v};
   assign ovf     = sum_ext[ACC_W] != sum_ext[ACC_W-1];
   assign sat_hit = hs && in_range && ovf;

   always_comb begin
      sum_res = sum_ext[ACC_W-1:0];
      if (ovf)
         sum_res = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign sum_res = base + {{(ACC_W - 16){in_v[15]}}, in_v};
`endif

   assign nx = (px == XMAX) ? '0 : px + 1'b1;
   assign ny = (px == XMAX) ? py + 1'b1 : py;

   assign out_x    = 4'(px);
   assign out_y    = 4'(py);
   assign out_data = out_valid ? acc[py][px] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int y = 0; y < OUT_H; y++)
            for (int x = 0; x < OUT_W; x++)
               acc[y][x] <= '0;
      end else begin
         if (clear) begin
            for (int y = 0; y < OUT_H; y++)
               for (int x = 0; x < OUT_W; x++)
                  acc[y][x] <= '0;
         end else if (state == DRAIN && out_hs) begin
            acc[py][px] <= '0;
         end
         if (hs && in_range)
            acc[ay][ax] <= sum_res;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ACCUM;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         px        <= '0;
         py        <= '0;
         drop_cnt  <= 8'd0;
`ifdef PSUM_SAT_EN
         sat_flag  <= 1'b0;
`endif
      end else begin
         unique case (state)
            ACCUM: begin
               if (clear) begin
                  drop_cnt <= 8'd0;
`ifdef PSUM_SAT_EN
                  sat_flag <= 1'b0;
`endif
               end
               if (hs) begin
                  if (!in_range) begin
                     if (clear)
                        drop_cnt <= 8'd1;
                     else if (drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                  end
`ifdef PSUM_SAT_EN
                  if (sat_hit)
                     sat_flag <= 1'b1;
`endif
                  if (in_last) begin
                     state     <= DRAIN;
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                     px        <= '0;
                     py        <= '0;
                     out_last  <= (OUT_W == 1) && (OUT_H == 1);
                  end
               end
            end
            DRAIN: begin
               if (clear || (out_ready && out_last)) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  px        <= '0;
                  py        <= '0;
                  drop_cnt  <= 8'd0;
`ifdef PSUM_SAT_EN
                  sat_flag  <= 1'b0;
`endif
               end else if (out_ready) begin
                  px       <= nx;
                  py       <= ny;
                  out_last <= (nx == XMAX) && (ny == YMAX);
               end
            end
         endcase
      end
   end

endmodule
